// File: rtl/input_chunk_buffer_if.sv
// Bus bundle for input_chunk_buffer: sample write side, chunk read side and status.
// The producer/consumer side uses master; the buffer uses slave.
interface input_chunk_buffer_if #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_PTR_BITS = 6
);
  logic [SAMPLE_SIZE-1:0]      sample_in;
  logic                        sample_valid;
  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr;
  logic [SAMPLE_SIZE-1:0]      input_buff_sample;
  logic                        chunk_pulse;
  logic                        chunk_done;
  logic                        overrun;
  logic                        overrun_clr;
  logic [IO_BUFF_PTR_BITS-1:0] wr_level;

  modport master (
    output sample_in, sample_valid, input_buff_ptr, chunk_done, overrun_clr,
    input  input_buff_sample, chunk_pulse, overrun, wr_level
  );

  modport slave (
    input  sample_in, sample_valid, input_buff_ptr, chunk_done, overrun_clr,
    output input_buff_sample, chunk_pulse, overrun, wr_level
  );
endinterface

// File: rtl/input_chunk_buffer.sv
// Ping-pong sample buffer: one bank fills from the sample stream while the other
// is presented to the consumer; banks swap on every full chunk.
module input_chunk_buffer #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_SIZE     = 64,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input logic                  clk,
  input logic                  rst,
  input_chunk_buffer_if.slave  bus
);
  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [SAMPLE_SIZE-1:0] bank_a [IO_BUFF_SIZE];
  logic [SAMPLE_SIZE-1:0] bank_b [IO_BUFF_SIZE];

  state_t                      state_q, state_d;
  logic [IO_BUFF_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic                        fill_b_q, fill_b_d;
  logic                        chunk_pulse_q, chunk_pulse_d;
  logic                        overrun_q, overrun_d;
  logic [SAMPLE_SIZE-1:0]      rd_data_q, rd_data_d;
  logic                        swap;

  assign swap = bus.sample_valid && (wr_ptr_q == LAST);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_b_d      = fill_b_q;
    overrun_d     = overrun_q;
    chunk_pulse_d = swap;
    // Presented bank is always the one not being filled.
    rd_data_d     = fill_b_q ? bank_a[bus.input_buff_ptr] : bank_b[bus.input_buff_ptr];

    if (bus.sample_valid) wr_ptr_d = swap ? '0 : wr_ptr_q + 1'b1;
    if (swap)             fill_b_d = ~fill_b_q;

    if (bus.overrun_clr) overrun_d = 1'b0;

    // A release coinciding with a swap counts as release-then-present.
    unique case (state_q)
      IDLE: begin
        if (swap) state_d = PENDING;
      end
      PENDING: begin
        if (swap) begin
          if (!bus.chunk_done) overrun_d = 1'b1;
        end else if (bus.chunk_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      fill_b_q      <= 1'b0;
      chunk_pulse_q <= 1'b0;
      overrun_q     <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_b_q      <= fill_b_d;
      chunk_pulse_q <= chunk_pulse_d;
      overrun_q     <= overrun_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.sample_valid) begin
      if (fill_b_q) bank_b[wr_ptr_q] <= bus.sample_in;
      else          bank_a[wr_ptr_q] <= bus.sample_in;
    end
  end

  assign bus.input_buff_sample = rd_data_q;
  assign bus.chunk_pulse       = chunk_pulse_q;
  assign bus.overrun           = overrun_q;
  assign bus.wr_level          = wr_ptr_q;
endmodule

// File: tb/tb_input_chunk_buffer.sv
// Randomized scoreboard bench for input_chunk_buffer against a chunk-level queue model.
module tb_input_chunk_buffer;
  localparam int SS = 24;
  localparam int N  = 64;
  localparam int PB = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  input_chunk_buffer_if #(.SAMPLE_SIZE(SS), .IO_BUFF_PTR_BITS(PB)) bus();

  input_chunk_buffer #(.SAMPLE_SIZE(SS), .IO_BUFF_SIZE(N), .IO_BUFF_PTR_BITS(PB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic pulse;
    logic ovr;
    int   lvl;
  } exp_t;

  exp_t            exp_q[$];
  logic [SS-1:0]   rd_q[$];

  // Model: samples of the chunk being filled, the chunk on display, release/overrun flags.
  logic [SS-1:0]   fill_m[$];
  logic [SS-1:0]   pres_m[N];
  bit              pres_ok   = 0;
  bit              pending_m = 0;
  bit              ovr_m     = 0;

  int n_cmp = 0;
  int n_err = 0;

  bit tag  = 0, tag_d;
  bit rtag = 0, rtag_d;

  always @(posedge clk or negedge rst)
    if (!rst) begin
      tag_d  <= 1'b0;
      rtag_d <= 1'b0;
    end else begin
      tag_d  <= tag;
      rtag_d <= rtag;
    end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle the stimulus has issued, decoupled from the driver.
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [SS-1:0] r;
    if (rst && tag_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL exp_q_underflow: got empty expected entry");
      end else begin
        e = exp_q.pop_front();
        check("chunk_pulse", bus.chunk_pulse, e.pulse);
        check("overrun", bus.overrun, e.ovr);
        check("wr_level", bus.wr_level, e.lvl);
      end
    end
    if (rst && rtag_d) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_q_underflow: got empty expected entry");
      end else begin
        r = rd_q.pop_front();
        check("input_buff_sample", bus.input_buff_sample, r);
      end
    end
  end

  task automatic step(input bit v, input logic [SS-1:0] d, input bit done, input bit clr,
                      input bit rd, input int ptr);
    bit sw;
    bus.sample_valid   = v;
    bus.sample_in      = d;
    bus.chunk_done     = done;
    bus.overrun_clr    = clr;
    bus.input_buff_ptr = PB'(ptr);
    rtag = rd && pres_ok;
    if (rtag) rd_q.push_back(pres_m[ptr]);
    sw = 0;
    if (v) begin
      fill_m.push_back(d);
      if (fill_m.size() == N) sw = 1;
    end
    if (sw && pending_m && !done) ovr_m = 1;
    else if (clr)                 ovr_m = 0;
    if (sw) begin
      for (int i = 0; i < N; i++) pres_m[i] = fill_m[i];
      fill_m.delete();
      pending_m = 1;
      pres_ok   = 1;
    end else if (done) begin
      pending_m = 0;
    end
    exp_q.push_back('{sw, ovr_m, fill_m.size()});
    tag = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    tag  = 0;
    rtag = 0;
    rst  = 1'b0;
    #1;
    check("rst_wr_level", bus.wr_level, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_chunk_pulse", bus.chunk_pulse, 0);
    check("rst_sample", bus.input_buff_sample, 0);
    fill_m.delete();
    pending_m = 0;
    ovr_m     = 0;
    pres_ok   = 0;
    bus.sample_valid   = 0;
    bus.sample_in      = '0;
    bus.chunk_done     = 0;
    bus.overrun_clr    = 0;
    bus.input_buff_ptr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1, SS'($urandom), 0, 0, rd, $urandom_range(0, N-1));
  endtask

  initial begin
    bus.sample_valid   = 0;
    bus.sample_in      = '0;
    bus.chunk_done     = 0;
    bus.overrun_clr    = 0;
    bus.input_buff_ptr = '0;
    do_reset();

    // Known-pattern chunk, then targeted reads.
    for (int k = 0; k < N; k++) step(1, SS'(k + 'h100), 0, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 5);
    step(0, '0, 0, 0, 1, 63);
    idle(2);

    // Back-to-back stream across three swaps with reads every cycle.
    fill(192, 1);
    step(0, '0, 0, 1, 0, 0);           // clear overrun
    step(0, '0, 1, 0, 0, 0);           // release
    fill(N, 1);
    step(0, '0, 1, 0, 1, 7);           // release between chunks
    fill(N, 0);                        // no overrun expected

    // Release coinciding with the swap write while pending.
    fill(N-1, 0);
    step(1, SS'($urandom), 1, 0, 0, 0);
    // Overrun set coinciding with clear.
    fill(N-1, 0);
    step(1, SS'($urandom), 0, 1, 0, 0);
    idle(2);
    step(0, '0, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom % 10) < 7, SS'($urandom), ($urandom % 20) == 0, ($urandom % 40) == 0,
           $urandom % 2, $urandom_range(0, N-1));

    // Reset mid-chunk with overrun set, then a fresh chunk read back in full.
    fill(2*N, 0);
    fill(30, 0);
    do_reset();
    for (int k = 0; k < N; k++) step(1, SS'(k + 'h5000), 0, 0, 0, 0);
    for (int k = 0; k < N; k++) step(0, '0, 0, 0, 1, k);
    idle(3);
    tag  = 0;
    rtag = 0;
    repeat (3) @(negedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
